sam_mem_arb: RTL

SAM_MEM_ARB -- requirements
Module: sam_mem_arb

---
 rtl/sam_pkg.sv | 21 ++
 rtl/sam_arb_prio.sv | 37 +++
 rtl/sam_mem_arb.sv | 106 ++++++++++
 3 files changed

// File: rtl/sam_pkg.sv
// Shared constants, state encoding and sizing helper for the SAM memory arbiter.
package sam_pkg;

    localparam int SAM_AW       = 32;
    localparam int SAM_DW       = 32;
    localparam int SAM_MAX_WAIT = 4;
    localparam int SAM_TMO      = 64;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_IF_WAIT = 2'd1,
        S_LS_WAIT = 2'd2,
        S_ERR     = 2'd3
    } sam_state_e;

    // Width needed to hold values 0..maxv inclusive.
    function automatic int cnt_w(input int maxv);
        return (maxv < 1) ? 1 : $clog2(maxv + 1);
    endfunction

endpackage

// File: rtl/sam_arb_prio.sv
// Fetch/load-store priority select with a saturating fetch-denial counter.
module sam_arb_prio
    import sam_pkg::*;
#(
    parameter int MAX_WAIT = SAM_MAX_WAIT
) (
    input  logic clk,
    input  logic RN,
    input  logic if_req,
    input  logic ls_req,
    input  logic grant_en,
    output logic if_win,
    output logic ls_win
);

    localparam int CW = cnt_w(MAX_WAIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    logic [CW-1:0] deny_q;
    logic          starved;

    // Load/store normally wins; a fetch denied MAX_WAIT times in a row takes the slot.
    assign starved = (deny_q == CNT_MAX);
    assign if_win  = grant_en & if_req & (~ls_req | starved);
    assign ls_win  = grant_en & ls_req & ~if_win;

    always_ff @(posedge clk) begin
        if (RN) begin
            deny_q <= '0;
        end else if (if_win) begin
            deny_q <= '0;
        end else if (ls_win && if_req && !starved) begin
            deny_q <= deny_q + 1'b1;
        end
    end

endmodule

// File: rtl/sam_mem_arb.sv
// Two-requester (fetch, load/store) single-outstanding memory arbiter with
// zero-latency response pass-through and a sticky response timeout.
module sam_mem_arb
    import sam_pkg::*;
#(
    parameter int AW       = SAM_AW,
    parameter int DW       = SAM_DW,
    parameter int MAX_WAIT = SAM_MAX_WAIT,
    parameter int TMO      = SAM_TMO
) (
    input  logic          clk,
    input  logic          RN,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall,
    output logic          err
);

    localparam int TW = cnt_w(TMO);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    sam_state_e    state_q;
    logic [TW-1:0] tmo_q;
    logic          err_q;
    logic          grant_en;
    logic          if_win;
    logic          ls_win;
    logic          wait_st;

    assign grant_en = (state_q == S_IDLE) & ~RN;
    assign wait_st  = (state_q == S_IF_WAIT) | (state_q == S_LS_WAIT);

    sam_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .clk      (clk),
        .RN       (RN),
        .if_req   (if_req),
        .ls_req   (ls_req),
        .grant_en (grant_en),
        .if_win   (if_win),
        .ls_win   (ls_win)
    );

    // Command fields are forced to zero whenever no command is issued.
    assign if_gnt    = if_win;
    assign ls_gnt    = ls_win;
    assign mem_req   = if_win | ls_win;
    assign mem_we    = ls_win & ls_we;
    assign mem_addr  = if_win ? if_addr : (ls_win ? ls_addr : '0);
    assign mem_wdata = mem_req ? ls_wdata : '0;

    // Responses only count while a transaction is outstanding; gnt never sees mem_rvalid.
    assign if_rvalid = ~RN & (state_q == S_IF_WAIT) & mem_rvalid;
    assign ls_rvalid = ~RN & (state_q == S_LS_WAIT) & mem_rvalid;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

    assign stall = ~RN & ((if_req & ~if_gnt) | (ls_req & ~ls_gnt) | wait_st);
    assign err   = err_q;

    always_ff @(posedge clk) begin
        if (RN) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tmo_q <= '0;
                    if (if_win)      state_q <= S_IF_WAIT;
                    else if (ls_win) state_q <= S_LS_WAIT;
                end
                S_IF_WAIT, S_LS_WAIT: begin
                    if (mem_rvalid) begin
                        state_q <= S_IDLE;
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_ERR: state_q <= S_ERR;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
